// File: rtl/bus_responder.sv
// bus_responder -- memory/peripheral end of the CPU read/write strobe bus.
//
// Detects falling edges of the active-low notWR/notRD strobes (sampled on the
// rising clock edge), captures address and write data, waits WAIT_STATES
// cycles, performs one access to an internal word store and then holds
// ready until the CPU releases the strobe.
//
// Parameters:
//   DATA_WIDTH  - data bus width
//   ADDR_BITS   - low address bits decoded; store depth is 2**ADDR_BITS words
//   WAIT_STATES - cycles between strobe detection and the access (0..15)
//
// Ports:
//   clock         - system clock, all state changes on posedge
//   reset         - asynchronous, active-high
//   notWR, notRD  - active-low write / read strobes from the CPU side
//   address       - 16-bit bus address
//   dataIn        - write data
//   dataOut       - registered read data, retained after the cycle ends
//   dataOutEnable - high while read data is valid (ACCESS through HOLD)
//   ready         - access complete, held until the strobe is released
//   collision     - one-cycle pulse when both strobes are seen low together
//   busError      - only with ADDR_CHECK_EN: upper address bits were nonzero
//
// Build option ADDR_CHECK_EN: when defined, accesses whose address has any
// bit set above ADDR_BITS complete with normal timing but do not touch the
// store (reads return 0) and raise busError alongside ready. When undefined,
// upper address bits are ignored and addresses alias.

module bus_responder #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_BITS   = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  notWR,
  input  logic                  notRD,
  input  logic [15:0]           address,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  dataOutEnable,
  output logic                  ready,
  output logic                  collision
`ifdef ADDR_CHECK_EN
  ,
  output logic                  busError
`endif
);

  localparam int         DEPTH     = 1 << ADDR_BITS;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, HOLD} stateT;

  stateT                 state;
  logic                  prevWR;
  logic                  prevRD;
  logic                  blocked;
  logic [3:0]            waitCount;
  logic                  opWrite;
  logic [ADDR_BITS-1:0]  addrReg;
  logic [DATA_WIDTH-1:0] dataReg;
  logic                  addrErr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic wrEdge;
  logic rdEdge;
  logic bothLow;
  logic startWrite;
  logic startRead;
  logic activeHigh;
  logic memWrite;

  assign wrEdge  = !notWR && prevWR;
  assign rdEdge  = !notRD && prevRD;
  assign bothLow = !notWR && !notRD;

  // An access starts only from a fresh edge with the other strobe idle.
  assign startWrite = (state == IDLE) && !blocked && wrEdge && notRD;
  assign startRead  = (state == IDLE) && !blocked && rdEdge && notWR;

  // Release of whichever strobe started the current access.
  assign activeHigh = opWrite ? notWR : notRD;

`ifdef ADDR_CHECK_EN
  always_ff @(posedge clock) begin
    if (startWrite || startRead) begin
      addrErr <= |address[15:ADDR_BITS];
    end
  end
`else
  logic unusedUpperAddr;
  assign unusedUpperAddr = ^address[15:ADDR_BITS];
  assign addrErr = 1'b0;
`endif

  // Captured address and data are pure datapath and need no reset.
  always_ff @(posedge clock) begin
    if (startWrite || startRead) begin
      addrReg <= address[ADDR_BITS-1:0];
      dataReg <= dataIn;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] readWord(input logic err,
                                                     input logic [DATA_WIDTH-1:0] word);
    return err ? '0 : word;
  endfunction

  // Reset forces state to IDLE asynchronously, so a pending write never lands.
  assign memWrite = (state == ACCESS) && opWrite && !addrErr && !reset;

  always_ff @(posedge clock) begin
    if (memWrite) begin
      mem[addrReg] <= dataReg;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      ready         <= 1'b0;
      dataOutEnable <= 1'b0;
      dataOut       <= '0;
      collision     <= 1'b0;
      prevWR        <= 1'b1;
      prevRD        <= 1'b1;
      blocked       <= 1'b0;
      waitCount     <= '0;
      opWrite       <= 1'b0;
`ifdef ADDR_CHECK_EN
      busError      <= 1'b0;
`endif
    end else begin
      prevWR    <= notWR;
      prevRD    <= notRD;
      collision <= 1'b0;
      case (state)
        IDLE: begin
          if (blocked) begin
            // After a collision, wait for both strobes idle before rearming.
            if (notWR && notRD) begin
              blocked <= 1'b0;
            end
          end else if (bothLow) begin
            collision <= 1'b1;
            blocked   <= 1'b1;
          end else if (startWrite || startRead) begin
            opWrite   <= startWrite;
            waitCount <= WAIT_INIT;
            state     <= (WAIT_STATES == 0) ? ACCESS : WAIT;
          end
        end
        WAIT: begin
          // Abort takes priority over completing the wait.
          if (activeHigh) begin
            state <= IDLE;
          end else if (waitCount <= 4'd1) begin
            state <= ACCESS;
          end else begin
            waitCount <= waitCount - 4'd1;
          end
        end
        ACCESS: begin
          if (!opWrite) begin
            dataOut       <= readWord(addrErr, mem[addrReg]);
            dataOutEnable <= 1'b1;
          end
          ready <= 1'b1;
`ifdef ADDR_CHECK_EN
          busError <= addrErr;
`endif
          state <= HOLD;
        end
        HOLD: begin
          if (activeHigh) begin
            ready         <= 1'b0;
            dataOutEnable <= 1'b0;
`ifdef ADDR_CHECK_EN
            busError      <= 1'b0;
`endif
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_responder.sv
// Bench for bus_responder: instance u0 with two wait states, instance u1
// with none. Expected access results are queued when a strobe is driven and
// compared when the responder raises ready.

module tb_bus_responder;

  localparam int WS0 = 2;
  localparam int WS1 = 0;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  notWR = 2'b11;
  logic [1:0]  notRD = 2'b11;
  logic [15:0] address = '0;
  logic [15:0] dataIn = '0;
  logic [15:0] dataOut [2];
  logic        dataOutEnable [2];
  logic        ready [2];
  logic        collision [2];
`ifdef ADDR_CHECK_EN
  logic        busError [2];
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          isRead;
    logic [15:0] data;
    bit          err;
  } expT;

  expT         sb[$];
  logic [15:0] modelMem [2][256];

  always #5 clock = ~clock;

  bus_responder #(.DATA_WIDTH(16), .ADDR_BITS(8), .WAIT_STATES(WS0)) u0 (
    .clock(clock), .reset(reset), .notWR(notWR[0]), .notRD(notRD[0]),
    .address(address), .dataIn(dataIn), .dataOut(dataOut[0]),
    .dataOutEnable(dataOutEnable[0]), .ready(ready[0]), .collision(collision[0])
`ifdef ADDR_CHECK_EN
    , .busError(busError[0])
`endif
  );

  bus_responder #(.DATA_WIDTH(16), .ADDR_BITS(8), .WAIT_STATES(WS1)) u1 (
    .clock(clock), .reset(reset), .notWR(notWR[1]), .notRD(notRD[1]),
    .address(address), .dataIn(dataIn), .dataOut(dataOut[1]),
    .dataOutEnable(dataOutEnable[1]), .ready(ready[1]), .collision(collision[1])
`ifdef ADDR_CHECK_EN
    , .busError(busError[1])
`endif
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int wsOf(input int u);
    return (u == 0) ? WS0 : WS1;
  endfunction

  // Full strobe cycle on instance u; checks latency, result and release.
  task automatic access(input int u, input bit isWr, input logic [15:0] addr,
                        input logic [15:0] data);
    expT e;
    expT got;
    int  n;
    e.isRead = !isWr;
`ifdef ADDR_CHECK_EN
    e.err = (addr[15:8] != 8'h00);
`else
    e.err = 1'b0;
`endif
    e.data = e.err ? 16'h0000 : modelMem[u][addr[7:0]];
    if (isWr && !e.err) modelMem[u][addr[7:0]] = data;
    sb.push_back(e);

    @(negedge clock);
    address = addr;
    dataIn  = data;
    if (isWr) notWR[u] = 1'b0;
    else      notRD[u] = 1'b0;

    n = 0;
    do begin
      @(negedge clock);
      n++;
      if (n == 1) begin
        // Bus changes after capture must not affect the access.
        address = ~addr;
        dataIn  = ~data;
      end
    end while (ready[u] !== 1'b1 && n < 40);

    checkEq($sformatf("latency u%0d", u), n, wsOf(u) + 2);
    got = sb.pop_front();
    if (ready[u] === 1'b1) begin
      checkEq("dataOutEnable at ready", dataOutEnable[u], got.isRead);
      if (got.isRead) checkEq($sformatf("rdata u%0d @%h", u, addr), dataOut[u], got.data);
`ifdef ADDR_CHECK_EN
      checkEq("busError at ready", busError[u], got.err);
`endif
      @(negedge clock);
      checkEq("ready held", ready[u], 1'b1);
      checkEq("dataOutEnable held", dataOutEnable[u], got.isRead);
    end

    if (isWr) notWR[u] = 1'b1;
    else      notRD[u] = 1'b1;
    @(negedge clock);
    checkEq("ready released", ready[u], 1'b0);
    checkEq("dataOutEnable released", dataOutEnable[u], 1'b0);
`ifdef ADDR_CHECK_EN
    checkEq("busError released", busError[u], 1'b0);
`endif
    if (got.isRead) checkEq("dataOut retained", dataOut[u], got.data);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clock);
    for (int u = 0; u < 2; u++) begin
      checkEq("reset ready", ready[u], 1'b0);
      checkEq("reset dataOutEnable", dataOutEnable[u], 1'b0);
      checkEq("reset dataOut", dataOut[u], 16'h0);
      checkEq("reset collision", collision[u], 1'b0);
    end
    reset = 1'b0;
    @(negedge clock);

    // Write then read with wait states
    access(0, 1'b1, 16'h0012, 16'hBEEF);
    access(0, 1'b0, 16'h0012, 16'h0000);

    // Zero wait states
    access(1, 1'b1, 16'h0005, 16'h1234);
    access(1, 1'b0, 16'h0005, 16'h0000);

    // Abort during WAIT
    access(0, 1'b1, 16'h0020, 16'h5555);
    @(negedge clock);
    address = 16'h0020;
    dataIn  = 16'hAAAA;
    notWR[0] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    notWR[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checkEq("abort no ready", ready[0], 1'b0);
    end
    access(0, 1'b0, 16'h0020, 16'h0000);

    // Collision
    @(negedge clock);
    address = 16'h0012;
    dataIn  = 16'h7777;
    notWR[0] = 1'b0;
    notRD[0] = 1'b0;
    @(negedge clock);
    checkEq("collision pulse", collision[0], 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checkEq("collision single", collision[0], 1'b0);
      checkEq("collision no ready", ready[0], 1'b0);
    end
    notWR[0] = 1'b1;
    notRD[0] = 1'b1;
    @(negedge clock);
    access(0, 1'b0, 16'h0012, 16'h0000);

    // Out-of-range address: error or alias depending on build
    access(0, 1'b1, 16'h0112, 16'h0F0F);
    access(0, 1'b0, 16'h0012, 16'h0000);
    access(0, 1'b0, 16'h0112, 16'h0000);

    // Reset during WAIT discards the write and clears outputs at once
    access(0, 1'b0, 16'h0005 + 16'h000D, 16'h0000);
    @(negedge clock);
    address = 16'h0012;
    dataIn  = 16'hDEAD;
    notWR[0] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    checkEq("async reset ready", ready[0], 1'b0);
    checkEq("async reset dataOutEnable", dataOutEnable[0], 1'b0);
    checkEq("async reset dataOut", dataOut[0], 16'h0);
    @(negedge clock);
    reset = 1'b0;
    notWR[0] = 1'b1;
    @(negedge clock);
    access(0, 1'b0, 16'h0012, 16'h0000);

    // Mixed traffic on both instances
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a;
      logic [15:0] d;
      a = 16'($urandom_range(64, 255));
      d = 16'($urandom);
      access(i % 2, 1'b1, a, d);
      access(i % 2, 1'b0, a, 16'h0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
